// File: rtl/hog_cell_ctrl.sv
// HOG cell sequencing controller.
// Feeds accepted pixel groups into the fixed 2-cycle gradient/bin datapath, tracks each pixel
// through it, sums the 9 bin outputs over one cell and presents the finished histogram on a
// one-deep valid/ready buffer. The last pixel of a cell is held off while the previous
// histogram is still pending, so the buffer is never overwritten.
module hog_cell_ctrl #(
   parameter int unsigned PIX_W    = 8,
   parameter int unsigned MAG_I    = 9,
   parameter int unsigned MAG_F    = 16,
   parameter int unsigned CELL_PIX = 64,
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned ACC_W    = MAG_I + MAG_F + CNT_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [4*PIX_W-1:0]           in_pixel,
   output logic [4*PIX_W-1:0]           dp_pixel,
   input  logic [9*(MAG_I+MAG_F)-1:0]   dp_bins,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [9*ACC_W-1:0]           out_hist,
   output logic [15:0]                  out_cell_idx
);

   localparam int unsigned BIN_W = MAG_I + MAG_F;
   localparam int unsigned NBINS = 9;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CELL_PIX - 1);

   logic             accept;
   logic             stall;
   logic             cell_done;
   logic [CNT_W-1:0] icnt_q, icnt_d;
   logic [CNT_W-1:0] acnt_q, acnt_d;
   logic             v1_q, v2_q;
   logic [ACC_W-1:0] acc_b_q [NBINS];
   logic [ACC_W-1:0] sum_d   [NBINS];

   // Input handshake: hold off the cell's last pixel while the previous histogram is pending.
   // The same-edge output handshake releases the stall in that cycle.
   always_comb begin
      stall    = (icnt_q == LAST) && out_valid && !out_ready;
      in_ready = rst && !clr && !stall;
      accept   = in_valid && in_ready;
      dp_pixel = accept ? in_pixel : '0;
   end

   // Issue and accumulate counters, both wrapping at the cell size; clr abandons the cell.
   always_comb begin
      icnt_d = icnt_q;
      acnt_d = acnt_q;
      if (clr) begin
         icnt_d = '0;
         acnt_d = '0;
      end else begin
         if (accept) begin
            icnt_d = (icnt_q == LAST) ? '0 : icnt_q + CNT_W'(1);
         end
         if (v2_q) begin
            acnt_d = (acnt_q == LAST) ? '0 : acnt_q + CNT_W'(1);
         end
      end
      cell_done = v2_q && !clr && (acnt_q == LAST);
   end

   // Running bin sums; the first pixel of a cell restarts each sum from its own bin value.
   always_comb begin
      for (int i = 0; i < NBINS; i++) begin
         sum_d[i] = ((acnt_q == '0) ? '0 : acc_b_q[i]) + ACC_W'(dp_bins[i*BIN_W +: BIN_W]);
      end
   end

   // Pipeline tracking, accumulation and the one-deep histogram output buffer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         v1_q         <= 1'b0;
         v2_q         <= 1'b0;
         icnt_q       <= '0;
         acnt_q       <= '0;
         out_valid    <= 1'b0;
         out_hist     <= '0;
         out_cell_idx <= '0;
         for (int i = 0; i < NBINS; i++) begin
            acc_b_q[i] <= '0;
         end
      end else begin
         v1_q   <= accept;
         v2_q   <= v1_q && !clr;
         icnt_q <= icnt_d;
         acnt_q <= acnt_d;
         if (v2_q && !clr) begin
            for (int i = 0; i < NBINS; i++) begin
               acc_b_q[i] <= sum_d[i];
            end
         end
         if (out_valid && out_ready) begin
            out_valid    <= 1'b0;
            out_cell_idx <= out_cell_idx + 16'd1;
         end
         // Completion never meets a pending histogram, so it safely overrides the clear above.
         if (cell_done) begin
            out_valid <= 1'b1;
            for (int i = 0; i < NBINS; i++) begin
               out_hist[i*ACC_W +: ACC_W] <= sum_d[i];
            end
         end
      end
   end

   // A completing cell must never find an unconsumed histogram in the buffer.
   no_overwrite: assert property (@(posedge clk) disable iff (!rst)
      cell_done |-> (!out_valid || out_ready));

endmodule

// File: tb/tb_hog_cell_ctrl.sv
// Scoreboard bench for hog_cell_ctrl with a behavioural datapath and cell-level reference model.
module tb_hog_cell_ctrl;
   localparam int PIX_W = 8, MAG_I = 9, MAG_F = 16, CELL_PIX = 64, CNT_W = 8;
   localparam int ACC_W = MAG_I + MAG_F + CNT_W;
   localparam int BIN_W = MAG_I + MAG_F;
   localparam int NB = 9;

   logic clk, rst, clr, in_valid, in_ready, out_valid, out_ready;
   logic [4*PIX_W-1:0] in_pixel, dp_pixel;
   logic [NB*BIN_W-1:0] dp_bins;
   logic [NB*ACC_W-1:0] out_hist;
   logic [15:0] out_cell_idx;

   hog_cell_ctrl #(.PIX_W(PIX_W), .MAG_I(MAG_I), .MAG_F(MAG_F), .CELL_PIX(CELL_PIX),
                   .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
      .in_pixel(in_pixel), .dp_pixel(dp_pixel), .dp_bins(dp_bins), .out_valid(out_valid),
      .out_ready(out_ready), .out_hist(out_hist), .out_cell_idx(out_cell_idx));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int edge_n = 0;
   int mode = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic chk(input string name, input logic [NB*ACC_W-1:0] act,
                      input logic [NB*ACC_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %h expected %h", name, edge_n, act, exp);
      end
   endtask

   // Bin values the datapath produces for a pixel group under each stimulus mode.
   function automatic logic [NB*BIN_W-1:0] dpf(input int m, input logic [31:0] p);
      logic [NB*BIN_W-1:0] r;
      logic [31:0] h;
      r = '0;
      for (int i = 0; i < NB; i++) begin
         h = (p * 32'h9E3779B1) ^ (32'(i) * 32'h85EBCA6B);
         h = h ^ (h >> 13);
         case (m)
            0: if (i == 0) r[i*BIN_W +: BIN_W] = 25'h10000;
            1: if (i == 1) r[i*BIN_W +: BIN_W] = 25'd1;
            2: r[i*BIN_W +: BIN_W] = 25'h1FFFFFF;
            3: r[i*BIN_W +: BIN_W] = h[24:0];
            default: if (i == 0) r[i*BIN_W +: BIN_W] = 25'd1;
         endcase
      end
      return r;
   endfunction

   // Datapath model: two register stages from dp_pixel to dp_bins.
   logic [NB*BIN_W-1:0] d1, d2;
   always @(posedge clk) begin
      d1 <= dpf(mode, dp_pixel);
      d2 <= d1;
   end
   assign dp_bins = d2;

   typedef struct packed {
      logic [NB*ACC_W-1:0] hist;
      logic [15:0]         idx;
      int                  due;
   } exp_t;

   // Reference model state: pixels of the open cell, pending histogram, consumed count.
   exp_t  sb[$];
   int    due_q[$];
   int    m_cnt = 0;
   int    m_cells = 0;
   longint m_sum[NB];
   bit    exp_ov = 0;
   logic [15:0] exp_idx = '0;
   bit    m_acc = 0;
   bit    exp_rdy;
   logic [31:0] exp_dp;
   logic [NB*BIN_W-1:0] mb;
   exp_t  ent;

   // Checks cycle-level outputs, then advances the model across the coming edge.
   always @(negedge clk) begin
      exp_rdy = rst && !clr && !(m_cnt == CELL_PIX - 1 && exp_ov && !out_ready);
      m_acc   = in_valid && exp_rdy;
      exp_dp  = m_acc ? in_pixel : '0;
      if (edge_n >= 1) begin
         chk("in_ready", in_ready, exp_rdy);
         chk("out_valid", out_valid, exp_ov);
         chk("dp_pixel", dp_pixel, exp_dp);
         chk("out_cell_idx", out_cell_idx, exp_idx);
      end
      if (!rst) begin
         m_cnt = 0; m_cells = 0; exp_ov = 0; exp_idx = '0;
         for (int i = 0; i < NB; i++) m_sum[i] = 0;
         due_q.delete();
         sb.delete();
      end else begin
         if (clr) begin
            m_cnt = 0;
            for (int i = 0; i < NB; i++) m_sum[i] = 0;
         end
         if (m_acc) begin
            mb = dpf(mode, in_pixel);
            for (int i = 0; i < NB; i++) m_sum[i] += longint'(mb[i*BIN_W +: BIN_W]);
            m_cnt++;
            if (m_cnt == CELL_PIX) begin
               for (int i = 0; i < NB; i++) ent.hist[i*ACC_W +: ACC_W] = ACC_W'(m_sum[i]);
               ent.idx = 16'(m_cells);
               ent.due = edge_n + 3;
               sb.push_back(ent);
               due_q.push_back(edge_n + 3);
               m_cells++;
               m_cnt = 0;
               for (int i = 0; i < NB; i++) m_sum[i] = 0;
            end
         end
         if (exp_ov && out_ready) begin
            exp_ov = 0;
            exp_idx = exp_idx + 16'd1;
         end
         if (due_q.size() > 0 && due_q[0] == edge_n + 1) begin
            exp_ov = 1;
            void'(due_q.pop_front());
         end
      end
   end

   // Monitor: pops the scoreboard whenever a new histogram is presented.
   bit prev_ov = 0;
   logic [NB*ACC_W-1:0] held = '0;
   exp_t got;
   always @(negedge clk) begin
      if (edge_n >= 1) begin
         if (out_valid && !prev_ov) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_hist at edge %0d: got %h expected none", edge_n,
                        out_hist);
            end else begin
               got = sb.pop_front();
               chk("hist", out_hist, got.hist);
               chk("hist_idx", out_cell_idx, got.idx);
               chk("latency", edge_n, got.due);
               held = got.hist;
            end
         end else if (out_valid) begin
            chk("hist_hold", out_hist, held);
         end
         prev_ov = out_valid;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] p);
      bit ok, a;
      ok = 0;
      in_valid = 1'b1;
      in_pixel = p;
      for (int t = 0; t < 2000; t++) begin
         @(posedge clk);
         a = m_acc;
         #1;
         if (a) begin
            ok = 1;
            break;
         end
      end
      in_valid = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout at edge %0d: got no accept expected accept", edge_n);
      end
   endtask

   task automatic stream(input int n, input bit gap);
      for (int k = 0; k < n; k++) begin
         send($urandom);
         if (gap) tick();
      end
   endtask

   initial begin
      int stalled;
      rst = 1'b0; clr = 1'b0; in_valid = 1'b1; in_pixel = 32'hDEADBEEF; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_hist", out_hist, '0);
      chk("reset_valid", out_valid, 1'b0);
      chk("reset_idx", out_cell_idx, 16'd0);
      chk("reset_no_accept", dp_pixel, '0);
      rst = 1'b1;
      in_valid = 1'b0;
      tick();

      // Back-to-back cell.
      mode = 0;
      stream(64, 0);
      repeat (4) tick();

      // Backpressure across two cells with a one-cycle release pulse.
      out_ready = 1'b0;
      mode = 3;
      fork
         stream(128, 0);
         begin
            stalled = 0;
            for (int t = 0; t < 1000 && stalled < 5; t++) begin
               tick();
               if (m_cnt == CELL_PIX - 1 && exp_ov && in_valid) stalled++;
               else stalled = 0;
            end
            chk("stall_seen", 32'(stalled), 32'd5);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
         end
      join
      repeat (5) tick();
      out_ready = 1'b1;
      repeat (3) tick();

      // Gapped input.
      mode = 1;
      stream(64, 1);
      repeat (4) tick();

      // Maximum bin values.
      mode = 2;
      stream(64, 0);
      repeat (4) tick();

      // clr mid-cell while a histogram is pending.
      out_ready = 1'b0;
      mode = 0;
      stream(64, 0);
      repeat (4) tick();
      mode = 4;
      stream(30, 0);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      fork
         stream(64, 0);
         begin
            repeat (90) tick();
            out_ready = 1'b1;
         end
      join
      repeat (4) tick();

      // Random traffic with random backpressure and occasional clr.
      mode = 3;
      for (int c = 0; c < 800; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_pixel  = $urandom;
         out_ready = ($urandom_range(0, 2) != 0);
         clr       = (m_cnt >= 3) && ($urandom_range(0, 60) == 0);
         tick();
      end
      clr = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (10) tick();
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog at edge %0d: got timeout expected completion", edge_n);
      $fatal(1, "watchdog");
   end

endmodule
